// File: rtl/strobe_stall_pkg.sv
// Shared defaults and width helpers for the strobe/stall concentrator.
package strobe_stall_pkg;

  localparam int unsigned DEF_NUM_CH = 4;
  localparam int unsigned DEF_DEPTH  = 3;

  // Channel-tag width; a single channel still needs a 1-bit tag.
  function automatic int unsigned id_width(input int unsigned n);
    int unsigned w;
    w = 1;
    if (n > 1) begin
      w = unsigned'($clog2(n));
    end
    return w;
  endfunction

endpackage

// File: rtl/strobe_stall_mux_rr_arbiter.sv
// Combinational round-robin arbiter: searches from last_grant+1 (mod NUM_CH).
module rr_arbiter
  import strobe_stall_pkg::*;
#(
  parameter int unsigned NUM_CH = DEF_NUM_CH,
  parameter int unsigned ID_W   = id_width(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [ID_W-1:0]   last_grant,
  output logic [NUM_CH-1:0] grant,
  output logic [ID_W-1:0]   grant_idx,
  output logic              grant_valid
);

  // First requester after last_grant wins; with NUM_CH=1 this is a pass-through.
  always_comb begin
    int unsigned cand;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = 0;
    for (int unsigned off = 1; off <= NUM_CH; off++) begin
      cand = (32'(last_grant) + off) % NUM_CH;
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = ID_W'(cand);
      end
    end
  end

endmodule

// File: rtl/strobe_stall_mux.sv
// Multi-channel strobe/stall concentrator: per-channel pending counters
// feeding a round-robin arbiter and a single registered output event.
module strobe_stall_mux
  import strobe_stall_pkg::*;
#(
  parameter int unsigned NUM_CH = DEF_NUM_CH,
  parameter int unsigned DEPTH  = DEF_DEPTH,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1),
  parameter int unsigned ID_W   = id_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] source_strobe,
  output logic [NUM_CH-1:0] source_stall,
  output logic [NUM_CH-1:0] source_overflow,
  output logic              dest_strobe,
  output logic [ID_W-1:0]   dest_channel,
  input  logic              dest_stall
);

  logic [CNT_W-1:0]  count      [NUM_CH];
  logic [CNT_W-1:0]  count_next [NUM_CH];
  logic [NUM_CH-1:0] stall_next;
  logic [NUM_CH-1:0] accept;
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] arb_grant;
  logic [NUM_CH-1:0] grant;
  logic [ID_W-1:0]   grant_idx;
  logic              grant_valid;
  logic [ID_W-1:0]   last_grant;
  logic              out_free;

  // Output slot is free when empty or being consumed this cycle.
  assign out_free = !dest_strobe || !dest_stall;
  assign accept   = source_strobe & ~source_stall;

  // Channels with at least one pending event request the arbiter.
  always_comb begin
    req = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      req[i] = (count[i] != '0);
    end
  end

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .ID_W   (ID_W)
  ) u_arb (
    .req         (req),
    .last_grant  (last_grant),
    .grant       (arb_grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign grant = arb_grant & {NUM_CH{out_free}};

  // Next count (+accept, -grant) and the stall it implies; stall is only
  // deasserted below DEPTH, so count can neither overflow nor underflow.
  always_comb begin
    stall_next = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      count_next[i] = count[i] + CNT_W'(accept[i]) - CNT_W'(grant[i]);
      stall_next[i] = (count_next[i] == CNT_W'(DEPTH));
    end
  end

  // Per-channel counters, stall and sticky overflow flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        count[i] <= '0;
      end
      source_stall    <= '1;
      source_overflow <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        count[i] <= count_next[i];
      end
      source_stall    <= stall_next;
      source_overflow <= source_overflow | (source_strobe & source_stall);
    end
  end

  // Output event register and round-robin pointer; both hold while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      dest_strobe  <= 1'b0;
      dest_channel <= '0;
      last_grant   <= ID_W'(NUM_CH - 1);
    end else if (out_free) begin
      dest_strobe <= grant_valid;
      if (grant_valid) begin
        dest_channel <= grant_idx;
        last_grant   <= grant_idx;
      end
    end
  end

endmodule
